// File: rtl/wallace_mac_if.sv
// rtl/wallace_mac_if.sv - handshake bundle between the MAC accumulator and its producer/sink
interface wallace_mac_if #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 12,
   parameter int CNT_W  = 5
);
   logic              start;
   logic              clr;
   logic [PROD_W-1:0] prod_in;
   logic              prod_valid;
   logic              prod_ready;
   logic [ACC_W-1:0]  acc_out;
   logic              acc_valid;
   logic              acc_ready;
   logic [CNT_W-1:0]  beat_cnt;
   logic              overflow;
   logic              busy;

   // Producer/sink side: drives control, products and result acceptance.
   modport master (
      output start, clr, prod_in, prod_valid, acc_ready,
      input  prod_ready, acc_out, acc_valid, beat_cnt, overflow, busy
   );

   // Accumulator side.
   modport slave (
      input  start, clr, prod_in, prod_valid, acc_ready,
      output prod_ready, acc_out, acc_valid, beat_cnt, overflow, busy
   );
endinterface

// File: rtl/wallace_mac_accumulator.sv
// rtl/wallace_mac_accumulator.sv - sums a burst of multiplier products with sticky overflow
module wallace_mac_accumulator #(
   parameter int PROD_W    = 8,
   parameter int ACC_W     = 12,
   parameter int BURST_LEN = 16,
   parameter int CNT_W     = 5
) (
   input logic         clk,
   input logic         rst_n,
   wallace_mac_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W:0]   sum;

   // One extra bit on the adder captures the carry-out for the sticky flag.
   assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod_in};

   // Next-state and datapath update; clr outranks every other request.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (bus.clr) begin
         state_d = S_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_d = S_ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            S_ACCUM: begin
               if (bus.prod_valid) begin
                  acc_d = sum[ACC_W-1:0];
                  ovf_d = ovf_q | sum[ACC_W];
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_BEAT) begin
                     state_d = S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (bus.acc_ready) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers; reset discards any partial burst.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.prod_ready = (state_q == S_ACCUM);
   assign bus.acc_valid  = (state_q == S_DONE);
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.acc_out    = acc_q;
   assign bus.beat_cnt   = cnt_q;
   assign bus.overflow   = ovf_q;
endmodule
